sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive cycles inst_req may be denied before it wins priority.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port inst_req, input, 1, instruction-fetch read request.
REQ-005 SHALL have port inst_addr, input, 32, fetch address.
REQ-006 SHALL have port inst_addr_ok, output, 1, fetch request accepted this cycle.
REQ-007 SHALL have port inst_data_ok, output, 1, fetch data valid this cycle.
REQ-008 SHALL have port inst_rdata, output, 32, fetch data.
REQ-009 SHALL have port data_req, input, 1, load/store request.
REQ-010 SHALL have port data_wr, input, 1, 1 = store, 0 = load.
REQ-011 SHALL have port data_wstrb, input, 4, store byte enables.
REQ-012 SHALL have port data_addr, input, 32, load/store address.
REQ-013 SHALL have port data_wdata, input, 32, store data.
REQ-014 SHALL have port data_addr_ok, output, 1, load/store request accepted this cycle.
REQ-015 SHALL have port data_data_ok, output, 1, load/store completed this cycle.
REQ-016 SHALL have port data_rdata, output, 32, load data.
REQ-017 SHALL have port sram_en, output, 1, shared SRAM access enable.
REQ-018 SHALL have port sram_we, output, 4, shared SRAM byte write enables.
REQ-019 SHALL have port sram_addr, output, 32, shared SRAM address.
REQ-020 SHALL have port sram_wdata, output, 32, shared SRAM write data.
REQ-021 SHALL have port sram_rdata, input, 32, shared SRAM read data, valid one cycle after sram_en.

Function
REQ-022 SHALL grant at most one requester per cycle; the grant is combinational from the req inputs and the current state: addr_ok of the winner = 1, and sram_en/sram_addr/sram_we/sram_wdata are driven from the winner in the same cycle.
REQ-023 SHALL drive sram_we = data_wstrb when data wins with data_wr=1, and 4'b0000 otherwise.
REQ-024 SHALL use an FSM with states IDLE (no response owed), RESP_I (inst response owed), RESP_D (data response owed).
REQ-025 SHALL transition from any state to RESP_I on an inst grant, to RESP_D on a data grant, and to IDLE when there is no grant.
REQ-026 SHALL assert inst_data_ok exactly in RESP_I with inst_rdata = sram_rdata, and data_data_ok exactly in RESP_D with data_rdata = sram_rdata; stores also get data_data_ok.
REQ-027 SHALL accept a new grant in RESP_I/RESP_D cycles, so the throughput is 1 access/cycle and the latency from addr_ok to data_ok is exactly 1 cycle.
REQ-028 SHALL give data priority when both requests are present, unless starve_cnt == STARVE_MAX, in which case inst wins.
REQ-029 SHALL increment starve_cnt (saturating at STARVE_MAX) each cycle inst_req=1 and inst is not granted, and clear it on an inst grant or when inst_req=0.
REQ-030 SHALL issue no SRAM access when a req drops before addr_ok; requesters hold req/addr/wdata stable until addr_ok.
REQ-031 SHALL drive inst_rdata/data_rdata to 0 in cycles without the matching data_ok.

Reset
REQ-032 SHALL, while resetn=0 (asynchronously), force the state to IDLE, starve_cnt=0, and all outputs to 0, including the addr_ok/data_ok/sram_en outputs.
REQ-033 SHALL drop a response owed at reset assertion: no data_ok follows reset, and the first grant is possible in the first cycle with resetn=1.

Verification
REQ-034 SHALL cover a single fetch: inst_req=1, inst_addr=0x1C000000 -> inst_addr_ok=1 and sram_en=1 at the same address; next cycle inst_data_ok=1 with inst_rdata=sram_rdata.
REQ-035 SHALL cover collision: inst_req and data_req (load at 0x00000100) high together -> data_addr_ok first, inst_addr_ok the next cycle, and data_data_ok/inst_data_ok on consecutive cycles.
REQ-036 SHALL cover starvation: data_req held high for 10 cycles with inst_req high -> inst granted in the 5th cycle (STARVE_MAX=4), data granted in all other cycles.
REQ-037 SHALL cover a store: data_wr=1, wstrb=4'b0011, addr=0x200, wdata=0xDEADBEEF -> sram_we=0011 with matching address and data, and data_data_ok one cycle later.
REQ-038 SHALL cover back-to-back fetches: inst_req high for 4 cycles -> 4 addr_ok and 4 data_ok with no bubble.
REQ-039 SHALL cover reset mid-transfer: resetn low in the cycle after a load grant -> data_data_ok stays 0 and all outputs are 0 until release.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port (fetch/load-store) arbiter onto one single-cycle SRAM
module sram_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    // Counter wide enough to hold STARVE_MAX itself (also safe for STARVE_MAX = 0).
    localparam int CW = $clog2(STARVE_MAX + 2);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            inst_win, data_win;

    // State and starvation counter; reset drops any response still owed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Grant selection, next state, starvation update and all port outputs.
    always_comb begin
        inst_win     = 1'b0;
        data_win     = 1'b0;
        state_d      = IDLE;
        starve_d     = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        sram_en      = 1'b0;
        sram_we      = 4'b0000;
        sram_addr    = '0;
        sram_wdata   = '0;

        // Data normally wins a collision; a fetch denied long enough takes over.
        inst_win = resetn && inst_req && (!data_req || (starve_q == STARVE_LIM));
        data_win = resetn && data_req && !inst_win;

        if (inst_win) begin
            state_d = RESP_I;
        end else if (data_win) begin
            state_d = RESP_D;
        end

        if (inst_req && !inst_win) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + CW'(1);
        end

        inst_addr_ok = inst_win;
        data_addr_ok = data_win;
        sram_en      = inst_win || data_win;
        if (inst_win) begin
            sram_addr = inst_addr;
        end else if (data_win) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            sram_we    = data_wr ? data_wstrb : 4'b0000;
        end

        // SRAM read data arrives one cycle after the grant; route it to the owner.
        if (resetn && (state_q == RESP_I)) begin
            inst_data_ok = 1'b1;
            inst_rdata   = sram_rdata;
        end
        if (resetn && (state_q == RESP_D)) begin
            data_data_ok = 1'b1;
            data_rdata   = sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    sram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which response is owed next cycle (0 none, 1 fetch, 2 data)
    // and how many consecutive cycles the fetch side has been refused.
    int m_owed   = 0;
    int m_starve = 0;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [3:0]  wstrb;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] srd;
        logic        e_iaok;
        logic        e_daok;
        logic        e_idok;
        logic        e_ddok;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                          input logic [3:0] ws, input logic [31:0] da, input logic [31:0] wd,
                          input logic [31:0] srd);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_wstrb = ws;
        data_addr  = da;
        data_wdata = wd;
        sram_rdata = srd;
    endtask

    // Called just after a falling edge with inputs applied: check outputs against
    // the model, then advance the model across the coming rising edge.
    task automatic step();
        bit wi, wd;
        #2;
        if (!resetn) begin
            m_owed   = 0;
            m_starve = 0;
            wi = 0;
            wd = 0;
        end else begin
            wi = inst_req && (!data_req || m_starve >= STARVE_MAX);
            wd = data_req && !wi;
        end
        chk("inst_addr_ok", inst_addr_ok, wi);
        chk("data_addr_ok", data_addr_ok, wd);
        chk("sram_en", sram_en, wi || wd);
        chk("sram_we", sram_we, (wd && data_wr) ? data_wstrb : 4'b0000);
        if (wi) chk("sram_addr_i", sram_addr, inst_addr);
        if (wd) chk("sram_addr_d", sram_addr, data_addr);
        if (wd) chk("sram_wdata", sram_wdata, data_wdata);
        chk("inst_data_ok", inst_data_ok, m_owed == 1);
        chk("inst_rdata", inst_rdata, (m_owed == 1) ? sram_rdata : 32'h0);
        chk("data_data_ok", data_data_ok, m_owed == 2);
        chk("data_rdata", data_rdata, (m_owed == 2) ? sram_rdata : 32'h0);
        if (!resetn) begin
            chk("rst_sram_addr", sram_addr, 32'h0);
            chk("rst_sram_wdata", sram_wdata, 32'h0);
        end else begin
            m_owed   = wi ? 1 : (wd ? 2 : 0);
            m_starve = (inst_req && !wi) ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
        end
    endtask

    initial begin
        int inst_cycle, data_cnt, ia_cnt, id_cnt;
        bit inst_done;

        vecs[0] = '{1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h1C000000, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h11223344,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h11223344};
        vecs[2] = '{1'b1, 32'h1C000004, 1'b1, 1'b0, 4'h0, 32'h00000100, 32'h0, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h00000100, 32'h0};
        vecs[3] = '{1'b1, 32'h1C000004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hAAAA5555,
                    1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h1C000004, 32'hAAAA5555};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h5555AAAA,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h5555AAAA};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h00000200, 32'hDEADBEEF, 32'h0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0011, 32'h00000200, 32'h0};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h12345678,
                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h12345678};
        vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00009999,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};

        // Reset with both requesters active: everything must stay quiet.
        resetn = 1'b0;
        set_in(1'b1, 32'h1C000000, 1'b1, 1'b1, 4'hF, 32'h300, 32'h55, 32'h77);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            step();
        end

        // Directed vectors: single fetch, collision, store.
        @(negedge clk);
        resetn = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_in(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwr, vecs[i].wstrb,
                   vecs[i].daddr, vecs[i].wdata, vecs[i].srd);
            step();
            chk($sformatf("vec%0d_iaok", i), inst_addr_ok, vecs[i].e_iaok);
            chk($sformatf("vec%0d_daok", i), data_addr_ok, vecs[i].e_daok);
            chk($sformatf("vec%0d_idok", i), inst_data_ok, vecs[i].e_idok);
            chk($sformatf("vec%0d_ddok", i), data_data_ok, vecs[i].e_ddok);
            chk($sformatf("vec%0d_en", i), sram_en, vecs[i].e_en);
            chk($sformatf("vec%0d_we", i), sram_we, vecs[i].e_we);
            if (vecs[i].e_en) chk($sformatf("vec%0d_addr", i), sram_addr, vecs[i].e_addr);
            if (vecs[i].e_we != 4'h0) chk($sformatf("vec%0d_wdata", i), sram_wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_irdata", i), inst_rdata, vecs[i].e_idok ? vecs[i].e_rd : 32'h0);
            chk($sformatf("vec%0d_drdata", i), data_rdata, vecs[i].e_ddok ? vecs[i].e_rd : 32'h0);
        end

        // Back-to-back fetches: four grants and four responses, no bubble.
        ia_cnt = 0;
        id_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(i < 4, 32'h1C000100 + 32'(4 * i), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, $urandom);
            step();
            if (inst_addr_ok) ia_cnt++;
            if (inst_data_ok) id_cnt++;
            if (i > 0) chk($sformatf("b2b_dok%0d", i), inst_data_ok, 1'b1);
        end
        chk("b2b_addr_ok_count", ia_cnt, 4);
        chk("b2b_data_ok_count", id_cnt, 4);

        // Starvation: fetch waits under continuous loads and wins on the 5th cycle.
        inst_cycle = 0;
        data_cnt   = 0;
        inst_done  = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            set_in(!inst_done, 32'h1C000200, 1'b1, 1'b0, 4'h0, 32'h400 + 32'(c), 32'h0, $urandom);
            step();
            if (inst_addr_ok) begin
                inst_cycle = c;
                inst_done  = 1;
            end
            if (data_addr_ok) data_cnt++;
        end
        chk("starve_inst_cycle", inst_cycle, STARVE_MAX + 1);
        chk("starve_data_grants", data_cnt, 9);
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, $urandom);
        step();

        // Reset in the cycle after a load grant: the owed response is dropped.
        @(negedge clk);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h00000100, 32'h0, 32'hCAFEF00D);
        step();
        chk("rmid_grant", data_addr_ok, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            resetn = 1'b0;
            set_in(1'b1, 32'h1C000000, 1'b1, 1'b0, 4'h0, 32'h00000104, 32'h0, 32'hBEEF0000);
            step();
            chk("rmid_ddok", data_data_ok, 1'b0);
            chk("rmid_en", sram_en, 1'b0);
        end
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk("rmid_first_grant", data_addr_ok, 1'b1);
        chk("rmid_no_ddok", data_data_ok, 1'b0);

        // Randomised traffic with occasional resets, checked by the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            resetn = ($urandom_range(0, 63) != 0);
            set_in($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1),
                   4'($urandom), $urandom, $urandom, $urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
